// File: rtl/input_cond.sv
// Input conditioner: per-channel synchronizer + debounce with edge pulses, plus an inactivity timer.
// Latency: input step to in_stable/in_rise/in_fall is SYNC_STAGES+DB_CYCLES cycles; timeout is one cycle behind tick_cnt.
// Backpressure: none; every output is a free-running registered level or a one-cycle pulse.
// Optional feature macro INPUT_COND_EDGE_WAKE_EN: debounced edge pulses also count as activity and restart the timer.
module input_cond #(
    parameter int NUM_IN      = 2,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 27000,
    parameter int MS_DIV      = 27000,
    parameter int TO_WIDTH    = 15
) (
    input  logic                clk27,
    input  logic                reset,
    input  logic [NUM_IN-1:0]   in_async,
    input  logic                activity_evt,
    input  logic                to_en,
    input  logic [TO_WIDTH-1:0] to_thresh,
    output logic [NUM_IN-1:0]   in_stable,
    output logic [NUM_IN-1:0]   in_rise,
    output logic [NUM_IN-1:0]   in_fall,
    output logic [TO_WIDTH-1:0] tick_cnt,
    output logic                timeout
);

    // Counter widths: the debounce counter only needs to reach DB_CYCLES-1,
    // the prescaler only MS_DIV-1 (MS_DIV >= 2 keeps PW >= 1).
    localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int PW  = $clog2(MS_DIV);

    localparam logic [DBW-1:0]      DB_LAST    = DBW'(DB_CYCLES - 1);
    localparam logic [PW-1:0]       PRESC_LAST = PW'(MS_DIV - 1);
    localparam logic [TO_WIDTH-1:0] TICK_MAX   = '1;

    // ------------------------------------------------------------------
    // Synchronizer chain: stage 0 samples the raw pins, last stage is the
    // only one the debouncer looks at.
    // ------------------------------------------------------------------
    logic [NUM_IN-1:0] sync_q [SYNC_STAGES];
    logic [NUM_IN-1:0] sync_out;

    assign sync_out = sync_q[SYNC_STAGES-1];

    // Shift every channel one stage per clock; reset flushes the chain.
    always_ff @(posedge clk27) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= in_async;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Debounce: a channel's counter runs only while the synchronized value
    // disagrees with the accepted level. Any cycle of agreement clears it,
    // so a glitch must persist DB_CYCLES consecutive cycles to be accepted.
    // ------------------------------------------------------------------
    logic [DBW-1:0]    db_cnt_q [NUM_IN];
    logic [DBW-1:0]    db_cnt_d [NUM_IN];
    logic [NUM_IN-1:0] stable_q, stable_d;
    logic [NUM_IN-1:0] rise_q,   rise_d;
    logic [NUM_IN-1:0] fall_q,   fall_d;

    // Next-state for counters, accepted level and edge pulses.
    always_comb begin
        stable_d = stable_q;
        rise_d   = '0;
        fall_d   = '0;
        for (int c = 0; c < NUM_IN; c++) begin
            db_cnt_d[c] = '0;
            if (sync_out[c] != stable_q[c]) begin
                if (db_cnt_q[c] == DB_LAST) begin
                    // Qualified: accept the new level and flag the edge in
                    // the same cycle the level changes. Counter restarts.
                    stable_d[c] = sync_out[c];
                    rise_d[c]   = sync_out[c];
                    fall_d[c]   = ~sync_out[c];
                end else begin
                    db_cnt_d[c] = db_cnt_q[c] + DBW'(1);
                end
            end
        end
    end

    // Register debounce state; reset aborts any qualification in progress
    // and never produces an edge pulse on entry or exit.
    always_ff @(posedge clk27) begin
        if (reset) begin
            for (int c = 0; c < NUM_IN; c++) begin
                db_cnt_q[c] <= '0;
            end
            stable_q <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
        end else begin
            for (int c = 0; c < NUM_IN; c++) begin
                db_cnt_q[c] <= db_cnt_d[c];
            end
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign in_stable = stable_q;
    assign in_rise   = rise_q;
    assign in_fall   = fall_q;

    // ------------------------------------------------------------------
    // Activity detection: the CPU toggles activity_evt, so any change from
    // the previously sampled level is one event.
    // ------------------------------------------------------------------
    logic evt_prev_q;
    logic activity;

    // Track the last sampled level, including during reset, so a level held
    // across reset release is not mistaken for a fresh event.
    always_ff @(posedge clk27) begin
        evt_prev_q <= activity_evt;
    end

`ifdef INPUT_COND_EDGE_WAKE_EN
    // Debounced edges on any channel also restart the inactivity timer.
    assign activity = (activity_evt != evt_prev_q) | (|(rise_q | fall_q));
`else
    // Only the CPU event restarts the timer; debounced edges are ignored here.
    assign activity = (activity_evt != evt_prev_q);
`endif

    // ------------------------------------------------------------------
    // Inactivity timer: prescaler divides clk27 down to ticks, tick counter
    // saturates at all-ones. Activity clears both and beats a coincident wrap.
    // ------------------------------------------------------------------
    logic [PW-1:0]       presc_q, presc_d;
    logic [TO_WIDTH-1:0] tick_q,  tick_d;
    logic                timeout_q, timeout_d;
    logic                wrap;

    assign wrap = (presc_q == PRESC_LAST);

    // Next-state for prescaler, tick counter and timeout flag.
    always_comb begin
        presc_d = presc_q;
        tick_d  = tick_q;
        if (activity) begin
            presc_d = '0;
            tick_d  = '0;
        end else if (wrap) begin
            presc_d = '0;
            if (tick_q != TICK_MAX) begin
                tick_d = tick_q + TO_WIDTH'(1);
            end
        end else begin
            presc_d = presc_q + PW'(1);
        end
        // Threshold and enable are sampled live; compare uses the current
        // count, so the flag trails tick_cnt by one cycle.
        timeout_d = to_en && (tick_q >= to_thresh);
    end

    // Register timer state.
    always_ff @(posedge clk27) begin
        if (reset) begin
            presc_q   <= '0;
            tick_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            tick_q    <= tick_d;
            timeout_q <= timeout_d;
        end
    end

    assign tick_cnt = tick_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_input_cond.sv
// Testbench for input_cond: directed scenarios then randomized stimulus, scored against a reference model.
// Latency: expected values are queued one edge ahead and compared 1ns after each rising edge.
// Backpressure: none; the monitor consumes exactly one expectation per clock.
`timescale 1ns/1ps
module tb_input_cond;

    localparam int NUM_IN = 2;
    localparam int SYNC   = 2;
    localparam int DB     = 4;
    localparam int MSD    = 10;
    localparam int TOW    = 4;
    localparam int TMAX   = (1 << TOW) - 1;

    logic              clk27 = 1'b0;
    logic              reset;
    logic [NUM_IN-1:0] in_async;
    logic              activity_evt;
    logic              to_en;
    logic [TOW-1:0]    to_thresh;
    logic [NUM_IN-1:0] in_stable, in_rise, in_fall;
    logic [TOW-1:0]    tick_cnt;
    logic              timeout;

    always #5 clk27 = ~clk27;

    input_cond #(
        .NUM_IN(NUM_IN), .SYNC_STAGES(SYNC), .DB_CYCLES(DB), .MS_DIV(MSD), .TO_WIDTH(TOW)
    ) dut (
        .clk27(clk27), .reset(reset), .in_async(in_async), .activity_evt(activity_evt),
        .to_en(to_en), .to_thresh(to_thresh), .in_stable(in_stable), .in_rise(in_rise),
        .in_fall(in_fall), .tick_cnt(tick_cnt), .timeout(timeout)
    );

    typedef struct {
        logic [NUM_IN-1:0] stable;
        logic [NUM_IN-1:0] rise;
        logic [NUM_IN-1:0] fall;
        int                tick;
        logic              to;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // ---------------- reference model ----------------
    // Inputs reach the debouncer through a plain delay line. A channel's new
    // level is accepted once the delayed value has held a value different from
    // the accepted level for DB consecutive edges (tracked by timestamp).
    // Ticks are elapsed edges since the last clear divided by MSD, saturated.
    int                edge_n = 0;
    logic [NUM_IN-1:0] m_dl [SYNC];
    logic [NUM_IN-1:0] m_stable = '0, m_rise = '0, m_fall = '0, m_seen = '0;
    int                m_since [NUM_IN];
    int                m_last_clear = 0;
    logic              m_prev_evt = 1'b0;

    function automatic int tick_at(int t);
        int v;
        v = (t - m_last_clear) / MSD;
        return (v > TMAX) ? TMAX : v;
    endfunction

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic model_edge();
        exp_t              e;
        logic              act;
        int                old_tick;
        logic [NUM_IN-1:0] cur;
        edge_n++;
        old_tick = tick_at(edge_n - 1);
        e.to = 1'b0;
        if (reset) begin
            for (int s = 0; s < SYNC; s++) m_dl[s] = '0;
            m_stable = '0; m_rise = '0; m_fall = '0; m_seen = '0;
            for (int c = 0; c < NUM_IN; c++) m_since[c] = edge_n;
            m_last_clear = edge_n;
            m_prev_evt   = activity_evt;
        end else begin
            cur = m_dl[SYNC-1];
            act = (activity_evt != m_prev_evt);
`ifdef INPUT_COND_EDGE_WAKE_EN
            act = act | (|(m_rise | m_fall));
`endif
            m_rise = '0;
            m_fall = '0;
            for (int c = 0; c < NUM_IN; c++) begin
                if (cur[c] != m_seen[c]) begin
                    m_seen[c]  = cur[c];
                    m_since[c] = edge_n;
                end
                if (cur[c] != m_stable[c] && (edge_n - m_since[c] + 1) >= DB) begin
                    m_stable[c] = cur[c];
                    if (cur[c]) m_rise[c] = 1'b1;
                    else        m_fall[c] = 1'b1;
                end
            end
            for (int s = SYNC - 1; s > 0; s--) m_dl[s] = m_dl[s-1];
            m_dl[0]    = in_async;
            m_prev_evt = activity_evt;
            e.to = to_en && (old_tick >= int'(to_thresh));
            if (act) m_last_clear = edge_n;
        end
        e.stable = m_stable;
        e.rise   = m_rise;
        e.fall   = m_fall;
        e.tick   = tick_at(edge_n);
        exp_q.push_back(e);
    endtask

    // Queue the expectation for the coming edge, then move past it.
    task automatic cyc();
        model_edge();
        @(negedge clk27);
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at edge-time %0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clk27);
            #1;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
            end else begin
                e = exp_q.pop_front();
                chk("in_stable", int'(in_stable), int'(e.stable));
                chk("in_rise",   int'(in_rise),   int'(e.rise));
                chk("in_fall",   int'(in_fall),   int'(e.fall));
                chk("tick_cnt",  int'(tick_cnt),  e.tick);
                chk("timeout",   int'(timeout),   int'(e.to));
                chk("rise_fall_exclusive", int'(in_rise & in_fall), 0);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int hold [NUM_IN];
        int rst_left;
        reset = 1'b1; in_async = '0; activity_evt = 1'b1; to_en = 1'b1; to_thresh = 4'd3;
        repeat (4) cyc();
        reset = 1'b0;
        repeat (2) cyc();

        // Clean step on channel 0, then a 3-cycle glitch on channel 1.
        in_async[0] = 1'b1;
        repeat (10) cyc();
        in_async[1] = 1'b1;
        repeat (3) cyc();
        in_async[1] = 1'b0;
        repeat (10) cyc();

        // Let the timer reach the threshold, then clear it by activity.
        repeat (30) cyc();
        activity_evt = ~activity_evt;
        repeat (5) cyc();

        // Activity landing exactly on a prescaler wrap.
        repeat (12) cyc();
        while (((edge_n - m_last_clear) % MSD) != MSD - 1) cyc();
        activity_evt = ~activity_evt;
        repeat (3) cyc();

        // Saturation, then a debounced fall on channel 0 at nonzero count.
        repeat (200) cyc();
        in_async[0] = 1'b0;
        repeat (12) cyc();

        // Reset with the event line high: no clear on release.
        reset = 1'b1; activity_evt = 1'b1;
        repeat (3) cyc();
        reset = 1'b0;
        repeat (15) cyc();

        // Zero threshold holds timeout high, even right after activity.
        to_thresh = '0;
        repeat (3) cyc();
        activity_evt = ~activity_evt;
        repeat (5) cyc();

        // Randomized phase.
        for (int c = 0; c < NUM_IN; c++) hold[c] = 0;
        rst_left = 0;
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NUM_IN; c++) begin
                if (hold[c] == 0) begin
                    in_async[c] = ~in_async[c];
                    hold[c] = $urandom_range(1, 12);
                end else begin
                    hold[c]--;
                end
            end
            if ($urandom_range(0, 39) == 0) activity_evt = ~activity_evt;
            if ($urandom_range(0, 49) == 0) to_en = ~to_en;
            if ($urandom_range(0, 49) == 0) to_thresh = TOW'($urandom_range(0, TMAX));
            if (rst_left > 0) begin
                rst_left--;
                reset = (rst_left > 0);
            end else if ($urandom_range(0, 399) == 0) begin
                rst_left = $urandom_range(1, 3);
                reset = 1'b1;
                if ($urandom_range(0, 1) == 0) activity_evt = ~activity_evt;
            end
            cyc();
        end
        reset = 1'b0;
        repeat (3) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
